// File: rtl/cache_pkg.sv
// Shared types and address-field layout for the write-through cache controller.
// Line = 4 words of 4 bytes; address is {tag, index, word, byte}.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        WRITE
    } state_e;

    localparam int BOFF_W   = 2;
    localparam int WOFF_W   = 2;
    localparam int IDX_W    = 2;
    localparam int TAG_W    = 10 - BOFF_W - WOFF_W - IDX_W;

    localparam int WOFF_LSB = BOFF_W;
    localparam int IDX_LSB  = BOFF_W + WOFF_W;
    localparam int TAG_LSB  = IDX_LSB + IDX_W;

endpackage

// File: rtl/wt_cache_store.sv
// Tag/valid/data arrays for the direct-mapped cache.
// Combinational read port, one synchronous line write, valid cleared on reset.
module wt_cache_store
    import cache_pkg::*;
#(
    parameter int LINES   = 4,
    parameter int IW      = 2,
    parameter int TW      = 4,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IW-1:0]      rd_idx_i,
    output logic [TW-1:0]      rd_tag_o,
    output logic               rd_valid_o,
    output logic [BLOCK_W-1:0] rd_data_o,
    input  logic               wr_en_i,
    input  logic [IW-1:0]      wr_idx_i,
    input  logic [TW-1:0]      wr_tag_i,
    input  logic [BLOCK_W-1:0] wr_data_i
);

    logic [LINES-1:0]   valid_q;
    logic [TW-1:0]      tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only valid bits are cleared.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/wt_cache_ctrl.sv
// Direct-mapped write-through, write-allocate cache controller (FSM + store).
// Define WT_CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module wt_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LINES   = 4,
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [WORD_W-1:0]  cpu_wdata,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    output logic               hit,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_ack
`ifdef WT_CACHE_STATS_EN
    ,
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt
`endif
);

    localparam int LIDX_W = $clog2(LINES);
    localparam int LTAG_W = ADDR_W - IDX_LSB - LIDX_W;
    localparam int LTAG_LSB = IDX_LSB + LIDX_W;
    localparam int NW = BLOCK_W / WORD_W;

    state_e              state_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                refill_q;
    logic                cpu_ready_q;
    logic [WORD_W-1:0]   cpu_rdata_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [BLOCK_W-1:0]  mem_wdata_q;

    logic [LTAG_W-1:0]   tag_w;
    logic [LIDX_W-1:0]   idx_w;
    logic [WOFF_W-1:0]   woff_w;
    logic [ADDR_W-1:0]   blk_addr_w;
    logic                unused_boff;

    logic [LTAG_W-1:0]   rd_tag;
    logic                rd_valid;
    logic [BLOCK_W-1:0]  rd_data;
    logic                match;
    logic                wr_en;
    logic [BLOCK_W-1:0]  wr_data;
    logic [BLOCK_W-1:0]  merged_d;
    logic [WORD_W-1:0]   word_d;

    assign tag_w       = addr_q[ADDR_W-1:LTAG_LSB];
    assign idx_w       = addr_q[LTAG_LSB-1:IDX_LSB];
    assign woff_w      = addr_q[IDX_LSB-1:WOFF_LSB];
    assign blk_addr_w  = {tag_w, idx_w, {IDX_LSB{1'b0}}};
    assign unused_boff = ^addr_q[WOFF_LSB-1:0];

    // A fill or an acked write-through both refresh the indexed line.
    assign wr_en = rst_n && mem_ack &&
                   ((state_q == FILL) || (state_q == WRITE));
    assign wr_data = (state_q == FILL) ? mem_rdata : mem_wdata_q;

    wt_cache_store #(
        .LINES   (LINES),
        .IW      (LIDX_W),
        .TW      (LTAG_W),
        .BLOCK_W (BLOCK_W)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (idx_w),
        .rd_tag_o   (rd_tag),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (idx_w),
        .wr_tag_i   (tag_w),
        .wr_data_i  (wr_data)
    );

    assign match = rd_valid && (rd_tag == tag_w);
    assign hit   = (state_q == LOOKUP) && match;

    always_comb begin
        merged_d = rd_data;
        word_d   = '0;
        for (int w = 0; w < NW; w++) begin
            if (WOFF_W'(w) == woff_w) begin
                merged_d[w*WORD_W +: WORD_W] = wdata_q;
                word_d = rd_data[w*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            refill_q    <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // The held request of the ready cycle must not re-issue.
                    if (cpu_req && !cpu_ready_q) begin
                        we_q     <= cpu_we;
                        addr_q   <= cpu_addr;
                        wdata_q  <= cpu_wdata;
                        refill_q <= 1'b0;
                        state_q  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (match && we_q) begin
                        mem_wdata_q <= merged_d;
                        mem_addr_q  <= blk_addr_w;
                        mem_we_q    <= 1'b1;
                        mem_req_q   <= 1'b1;
                        state_q     <= WRITE;
                    end else if (match) begin
                        cpu_rdata_q <= word_d;
                        cpu_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        mem_addr_q  <= blk_addr_w;
                        mem_we_q    <= 1'b0;
                        mem_req_q   <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        refill_q  <= 1'b1;
                        state_q   <= LOOKUP;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef WT_CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // Only the first lookup of a request counts; the post-fill one is skipped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if ((state_q == LOOKUP) && !refill_q) begin
            if (match && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end else if (!match && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_wt_cache_ctrl.sv
// Scoreboard bench for wt_cache_ctrl: directed CPU requests, a latency-
// configurable memory model, and a monitor that checks every response.
module tb_wt_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         hit;
    logic         mem_req;
    logic         mem_we;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;
`ifdef WT_CACHE_STATS_EN
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;
`endif

    always #5 clk = ~clk;

    wt_cache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef WT_CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    typedef struct {
        bit          is_store;
        logic [31:0] rdata;
        int          acks;
        int          lat;
    } cpu_exp_t;

    typedef struct {
        bit           we;
        logic [9:0]   addr;
        logic [127:0] wdata;
    } mem_exp_t;

    cpu_exp_t     exp_cpu[$];
    mem_exp_t     exp_mem[$];
    bit           exp_hit[$];
    logic [127:0] mem [64];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           ack_cnt = 0;
    int           lat = 3;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory model: checks each new request, then acks after `lat` cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                bit         we;
                logic [9:0] a;
                mem_exp_t   e;
                we = mem_we;
                a  = mem_addr;
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected", 1, 0);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_we", we, e.we);
                    chk("mem_addr", a, e.addr);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                end
                repeat (lat) @(posedge clk);
                #1;
                mem_ack = 1'b1;
                ack_cnt++;
                if (we) mem[a[9:4]] = mem_wdata;
                else    mem_rdata   = mem[a[9:4]];
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
            end
        end
    end

    // CPU-side monitor: first-lookup hit, response data, ordering, latency.
    initial begin
        bit pending  = 0;
        bit hit_next = 0;
        int ncyc = 0;
        int t0 = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst_n !== 1'b1) begin
                pending  = 0;
                hit_next = 0;
            end else begin
                if (hit_next) begin
                    hit_next = 0;
                    if (exp_hit.size() == 0) chk("hit_unexpected", 1, 0);
                    else chk("hit", hit, exp_hit.pop_front());
                end
                if (cpu_ready === 1'b1) begin
                    if (exp_cpu.size() == 0) begin
                        chk("ready_unexpected", 1, 0);
                    end else begin
                        cpu_exp_t e;
                        e = exp_cpu.pop_front();
                        if (!e.is_store) chk("rdata", cpu_rdata, e.rdata);
                        chk("ack_order", ack_cnt, e.acks);
                        if (e.lat > 0) chk("latency", ncyc - t0, e.lat);
                    end
                    pending = 0;
                end else if (cpu_req === 1'b1 && !pending) begin
                    pending  = 1;
                    hit_next = 1;
                    t0       = ncyc;
                end
            end
        end
    end

    task automatic issue(input bit we, input logic [9:0] a,
                         input logic [31:0] wd, input bit ehit,
                         input logic [31:0] erd, input int eacks,
                         input int elat);
        exp_hit.push_back(ehit);
        exp_cpu.push_back('{we, erd, eacks, elat});
        @(posedge clk);
        #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (cpu_ready === 1'b1) done = 1;
        end
        if (!done) chk("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[6'h03] = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
        mem[6'h13] = {32'h8888, 32'h7777, 32'h6666, 32'h5555};
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_hit", hit, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // Cold load, word 1 of line 0x030.
        exp_mem.push_back('{1'b0, 10'h030, '0});
        issue(0, 10'h034, '0, 0, 32'h2222, 1, 0);
        wait_done();

        // Load hit, two-cycle latency, no memory traffic.
        issue(0, 10'h034, '0, 1, 32'h2222, 1, 2);
        wait_done();

        // Store hit into word 0, written through.
        exp_mem.push_back('{1'b1, 10'h030,
            128'h00004444_00003333_00002222_DEADBEEF});
        issue(1, 10'h030, 32'hDEAD_BEEF, 1, '0, 2, 0);
        wait_done();

        // Conflicting store miss: fill 0x130, then write merged line.
        exp_mem.push_back('{1'b0, 10'h130, '0});
        exp_mem.push_back('{1'b1, 10'h130,
            128'h00008888_00007777_0000A5A5_00005555});
        issue(1, 10'h134, 32'h0000_A5A5, 0, '0, 4, 0);
        wait_done();
`ifdef WT_CACHE_STATS_EN
        chk("hit_cnt", hit_cnt, 2);
        chk("miss_cnt", miss_cnt, 2);
`endif

        // Evicted line refills with the written-through data.
        exp_mem.push_back('{1'b0, 10'h030, '0});
        issue(0, 10'h034, '0, 0, 32'h2222, 5, 0);
        wait_done();
        issue(0, 10'h030, '0, 1, 32'hDEAD_BEEF, 5, 2);
        wait_done();
        issue(0, 10'h03C, '0, 1, 32'h4444, 5, 2);
        wait_done();

        // Reset in the middle of a fill; the late ack must be ignored.
        lat = 8;
        exp_hit.push_back(0);
        exp_mem.push_back('{1'b0, 10'h130, '0});
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'h134;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (mem_req === 1'b1) seen = 1;
        end
        chk("abort_fill_started", seen, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_cpu_ready", cpu_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_late_ack", ack_cnt, 6);
        lat = 2;

        // All lines invalid after reset: a previously cached load misses.
        exp_mem.push_back('{1'b0, 10'h030, '0});
        issue(0, 10'h034, '0, 0, 32'h2222, 7, 0);
        wait_done();
        issue(0, 10'h030, '0, 1, 32'hDEAD_BEEF, 7, 2);
        wait_done();

        repeat (5) @(negedge clk);
        chk("exp_cpu_left", exp_cpu.size(), 0);
        chk("exp_mem_left", exp_mem.size(), 0);
        chk("exp_hit_left", exp_hit.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
